qif_neuron_scheduler: RTL and testbench

//  Time-multiplexes one QIF update datapath across N_NEURONS virtual neurons.
//  On each tick it walks every neuron once: reads its stored membrane voltage,

---
 rtl/qif_pkg.sv | 34 +++
 rtl/qif_update_unit.sv | 44 ++++
 rtl/qif_neuron_scheduler.sv | 142 ++++++++++++++
 tb/tb_qif_neuron_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/qif_pkg.sv
// qif_pkg
// Shared widths, the scheduler state encoding and the saturating clamp that
// the QIF neuron scheduler and its update unit use.
//   V_W    : stored membrane voltage width (signed)
//   ACC_W  : width of the update intermediate (holds V, V*V, sum without overflow)
//   state_t: scheduler FSM states
//   clamp_v: saturate an ACC_W signed value to the V_W signed range
package qif_pkg;

    localparam int V_W   = 8;
    localparam int ACC_W = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic signed [ACC_W-1:0] ACC_V_MAX = 18'sd127;
    localparam logic signed [ACC_W-1:0] ACC_V_MIN = -18'sd128;
    localparam logic signed [V_W-1:0]   V_MAX     = 8'sh7F;
    localparam logic signed [V_W-1:0]   V_MIN     = 8'sh80;

    function automatic logic signed [V_W-1:0] clamp_v(input logic signed [ACC_W-1:0] x);
        if (x > ACC_V_MAX) begin
            return V_MAX;
        end else if (x < ACC_V_MIN) begin
            return V_MIN;
        end else begin
            return signed'(x[V_W-1:0]);
        end
    endfunction

endpackage

// File: rtl/qif_update_unit.sv
// qif_update_unit
// Combinational quadratic integrate-and-fire step for one neuron:
//   v_next = clamp(v + (v*v >>> A_SHIFT) + i_syn), replaced by VRESET on a spike.
// Ports:
//   v       in   V_W  signed  current membrane voltage
//   i_syn   in   V_W  signed  synaptic input for this step
//   v_next  out  V_W  signed  voltage to write back
//   spike   out  1            saturated sum reached VPEAK
module qif_update_unit
    import qif_pkg::*;
#(
    parameter int A_SHIFT = 2,
    parameter int VPEAK   = 50,
    parameter int VRESET  = -20
) (
    input  logic signed [V_W-1:0] v,
    input  logic signed [V_W-1:0] i_syn,
    output logic signed [V_W-1:0] v_next,
    output logic                  spike
);

    localparam logic signed [V_W-1:0] VPEAK_V  = V_W'(VPEAK);
    localparam logic signed [V_W-1:0] VRESET_V = V_W'(VRESET);

    logic signed [ACC_W-1:0] v_ext;
    logic signed [ACC_W-1:0] i_ext;
    logic signed [ACC_W-1:0] sq;
    logic signed [ACC_W-1:0] quad;
    logic signed [ACC_W-1:0] sum;
    logic signed [V_W-1:0]   sat;

    always_comb begin
        v_ext = {{(ACC_W-V_W){v[V_W-1]}}, v};
        i_ext = {{(ACC_W-V_W){i_syn[V_W-1]}}, i_syn};
        // V*V peaks at 16384, so the 18-bit signed product never wraps
        sq    = v_ext * v_ext;
        quad  = sq >>> A_SHIFT;
        sum   = v_ext + quad + i_ext;
        sat   = clamp_v(sum);
        spike = (sat >= VPEAK_V);
        v_next = spike ? VRESET_V : sat;
    end

endmodule

// File: rtl/qif_neuron_scheduler.sv
// qif_neuron_scheduler
// Time-multiplexes one qif_update_unit over N_NEURONS virtual neurons. Each
// accepted tick latches all synaptic inputs and sweeps the neurons one per
// cycle, writing each updated voltage back and collecting spike bits.
// Ports:
//   clk        in   1             system clock, rising edge
//   rst_n      in   1             asynchronous active-low reset
//   tick_i     in   1             timestep request
//   i_syn_i    in   8*N_NEURONS   signed synaptic input, neuron n at [8n+7:8n]
//   busy_o     out  1             sweep in progress (CALC or DONE)
//   done_o     out  1             one-cycle sweep-complete pulse
//   spike_o    out  N_NEURONS     spike bits of the last completed sweep
//   overrun_o  out  1             sticky: tick seen while busy
//   rd_idx_i   in   log2(N)       readout neuron select
//   v_mem_o    out  8             stored voltage of neuron rd_idx_i
//
// state | meaning
// IDLE  | waiting for tick_i; a tick latches i_syn_i and starts a sweep
// CALC  | updating neuron idx this cycle, idx advances every cycle
// DONE  | sweep finished, done_o pulses, spike_o takes the accumulator
module qif_neuron_scheduler
    import qif_pkg::*;
#(
    parameter  int N_NEURONS = 4,
    parameter  int A_SHIFT   = 2,
    parameter  int VPEAK     = 50,
    parameter  int VRESET    = -20,
    localparam int IDX_W     = $clog2(N_NEURONS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tick_i,
    input  logic [V_W*N_NEURONS-1:0]   i_syn_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [N_NEURONS-1:0]       spike_o,
    output logic                       overrun_o,
    input  logic [IDX_W-1:0]           rd_idx_i,
    output logic signed [V_W-1:0]      v_mem_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [IDX_W-1:0]       idx;
    logic [N_NEURONS-1:0]   accum;
    logic signed [V_W-1:0]  v_mem     [N_NEURONS];
    logic signed [V_W-1:0]  i_syn_lat [N_NEURONS];
    logic signed [V_W-1:0]  v_next;
    logic                   spike;

    qif_update_unit #(
        .A_SHIFT (A_SHIFT),
        .VPEAK   (VPEAK),
        .VRESET  (VRESET)
    ) u_update (
        .v      (v_mem[idx]),
        .i_syn  (i_syn_lat[idx]),
        .v_next (v_next),
        .spike  (spike)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state)
            IDLE: begin
                if (tick_i) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                busy_o = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy_o    = 1'b1;
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            accum     <= '0;
            spike_o   <= '0;
            overrun_o <= 1'b0;
            for (int n = 0; n < N_NEURONS; n++) begin
                v_mem[n]     <= '0;
                i_syn_lat[n] <= '0;
            end
        end else begin
            if (tick_i && busy_o) begin
                overrun_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tick_i) begin
                        idx   <= '0;
                        accum <= '0;
                        for (int n = 0; n < N_NEURONS; n++) begin
                            i_syn_lat[n] <= i_syn_i[V_W*n +: V_W];
                        end
                    end
                end
                CALC: begin
                    v_mem[idx] <= v_next;
                    if (spike) begin
                        accum[idx] <= 1'b1;
                    end
                    // N_NEURONS is a power of two, so the last increment wraps to 0
                    idx <= idx + IDX_W'(1);
                end
                DONE: begin
                    spike_o <= accum;
                end
                default: begin
                end
            endcase
        end
    end

    assign v_mem_o = v_mem[rd_idx_i];

endmodule

// File: tb/tb_qif_neuron_scheduler.sv
// tb_qif_neuron_scheduler
// Directed bench for qif_neuron_scheduler (N=4, A_SHIFT=2, VPEAK=50, VRESET=-20):
// a table of sweeps with hand-computed voltages and spikes, then sequences for
// latency, overrun and asynchronous reset in the middle of a sweep.
module tb_qif_neuron_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_i = 1'b0;
    logic [31:0] i_syn_i = '0;
    logic        busy_o;
    logic        done_o;
    logic [3:0]  spike_o;
    logic        overrun_o;
    logic [1:0]  rd_idx_i = '0;
    logic signed [7:0] v_mem_o;

    int n_checks = 0;
    int n_fail   = 0;

    qif_neuron_scheduler #(
        .N_NEURONS (4),
        .A_SHIFT   (2),
        .VPEAK     (50),
        .VRESET    (-20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_i    (tick_i),
        .i_syn_i   (i_syn_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .spike_o   (spike_o),
        .overrun_o (overrun_o),
        .rd_idx_i  (rd_idx_i),
        .v_mem_o   (v_mem_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          do_reset;
        logic [31:0] isyn;
        logic [31:0] exp_v;
        logic [3:0]  exp_spike;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        tick_i = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_v(input string name, input logic [31:0] exp);
        for (int n = 0; n < 4; n++) begin
            rd_idx_i = 2'(n);
            #1;
            check($sformatf("%s v[%0d]", name, n), {{24{v_mem_o[7]}}, v_mem_o},
                  {{24{exp[8*n+7]}}, exp[8*n +: 8]});
        end
    endtask

    // Waits at negedges for done_o; a missing pulse is itself a failed check.
    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (done_o) seen = 1'b1;
        end
        check({name, " done seen"}, 32'(seen), 32'd1);
    endtask

    // One tick; i_syn_i is scrambled after acceptance to prove the latch.
    task automatic sweep(input string name, input logic [31:0] isyn);
        @(negedge clk);
        i_syn_i = isyn;
        tick_i  = 1'b1;
        @(negedge clk);
        tick_i  = 1'b0;
        i_syn_i = ~isyn;
        wait_done(name);
        @(negedge clk);
    endtask

    initial begin
        int dones;

        vecs[0] = '{1'b1, 32'h0A0A0A0A, 32'h0A0A0A0A, 4'b0000};
        vecs[1] = '{1'b0, 32'h0A0A0A0A, 32'h2D2D2D2D, 4'b0000};
        vecs[2] = '{1'b0, 32'h0A0A0A0A, 32'hECECECEC, 4'b1111};
        vecs[3] = '{1'b1, 32'h0A0A0A0A, 32'h0A0A0A0A, 4'b0000};
        vecs[4] = '{1'b0, 32'h0A0A0A0A, 32'h2D2D2D2D, 4'b0000};
        // n0: 45 + 506 + 127 = 678 -> 127 -> spike; others 551 -> spike
        vecs[5] = '{1'b0, 32'h0000007F, 32'hECECECEC, 4'b1111};
        // -20 + 100 - 60 = 20, no spike: spike_o must clear
        vecs[6] = '{1'b0, 32'hC4C4C4C4, 32'h14141414, 4'b0000};
        // n3 -128, n2 0, n1 60 -> spike/-20, n0 10
        vecs[7] = '{1'b1, 32'h80003C0A, 32'h8000EC0A, 4'b0010};

        #3;
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset done", 32'(done_o), 32'd0);
        check("reset spike", 32'(spike_o), 32'd0);
        check("reset overrun", 32'(overrun_o), 32'd0);
        check_v("reset", 32'h0);
        do_reset();

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].do_reset) do_reset();
            sweep($sformatf("vec%0d", i), vecs[i].isyn);
            check($sformatf("vec%0d spike", i), 32'(spike_o), 32'(vecs[i].exp_spike));
            check($sformatf("vec%0d busy", i), 32'(busy_o), 32'd0);
            check_v($sformatf("vec%0d", i), vecs[i].exp_v);
        end
        check("no overrun in table", 32'(overrun_o), 32'd0);

        // Latency: tick at edge T, busy in cycles T+1..T+5, done only in T+5
        do_reset();
        @(negedge clk);
        i_syn_i = 32'h0A0A0A0A;
        tick_i  = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            tick_i = 1'b0;
            check($sformatf("lat busy T+%0d", k), 32'(busy_o), 32'(k <= 5));
            check($sformatf("lat done T+%0d", k), 32'(done_o), 32'(k == 5));
        end
        // minimum period: a tick right now (T+6) is accepted without overrun
        tick_i = 1'b1;
        @(negedge clk);
        tick_i = 1'b0;
        check("back-to-back busy", 32'(busy_o), 32'd1);
        wait_done("back-to-back");
        @(negedge clk);
        check("back-to-back overrun", 32'(overrun_o), 32'd0);
        check_v("back-to-back", 32'h2D2D2D2D);

        // Overrun: second tick two cycles after the accepted one
        do_reset();
        @(negedge clk);
        i_syn_i = 32'h0A0A0A0A;
        tick_i  = 1'b1;
        @(negedge clk);
        tick_i = 1'b0;
        @(negedge clk);
        tick_i = 1'b1;
        @(negedge clk);
        tick_i = 1'b0;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            if (done_o) dones++;
            @(negedge clk);
        end
        check("overrun single sweep", 32'(dones), 32'd1);
        check("overrun flag", 32'(overrun_o), 32'd1);
        check_v("overrun", 32'h0A0A0A0A);
        sweep("after overrun", 32'h0A0A0A0A);
        check("overrun sticky", 32'(overrun_o), 32'd1);
        check_v("after overrun", 32'h2D2D2D2D);

        // Async reset with idx=2 in CALC
        do_reset();
        sweep("pre-abort", 32'h3C3C3C3C);
        check("pre-abort spike", 32'(spike_o), 32'hF);
        check_v("pre-abort", 32'hECECECEC);
        @(negedge clk);
        i_syn_i = 32'h0A0A0A0A;
        tick_i  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tick_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort at idx2 busy", 32'(busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy_o), 32'd0);
        check("abort spike", 32'(spike_o), 32'd0);
        check("abort done", 32'(done_o), 32'd0);
        check_v("abort", 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep("post-abort", 32'h0A0A0A0A);
        check("post-abort spike", 32'(spike_o), 32'd0);
        check_v("post-abort", 32'h0A0A0A0A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
